sin_cos_lut: RTL and testbench
==============================

SIN_COS_LUT -- requirements
Module: sin_cos_lut

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning output sample width in bits.
REQ-002 SHALL have parameter PHASE_W, default 8, meaning phase index width (256 samples per period).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: advance enable.
REQ-006 SHALL have port sampled_sine, output, DATA_W bits: signed two's-complement sine sample.
REQ-007 SHALL have port sampled_cosine, output, DATA_W bits: signed two's-complement cosine sample.

Function
REQ-008 SHALL hold an internal PHASE_W-bit phase counter p.
REQ-009 SHALL define S(k) = round(32767 * sin(2*pi*k/256)) for k in 0..255, with round-half-away-from-zero; peak magnitude is 32767 (0x7FFF / 0x8001), and -32768 is never produced.
REQ-010 SHALL, on each rising clk edge with en=1: sampled_sine <= S(p), sampled_cosine <= S((p+64) mod 256), p <= p+1.
REQ-011 SHALL, with en=0, hold p and both outputs unchanged.
REQ-012 SHALL register both outputs, giving one cycle of latency from the enabled edge; no combinational path from en to the outputs.
REQ-013 SHALL wrap p from 255 to 0 with no gap or repeated sample, so the period is exactly 256 enabled cycles.
REQ-014 SHALL derive S from a 65-entry quarter-wave table Q[i]=S(i), i=0..64. Quadrant q=k[7:6], idx=k[5:0]: q0 -> Q[idx]; q1 -> Q[64-idx]; q2 -> -Q[idx]; q3 -> -Q[64-idx].
REQ-015 SHALL compute negation in DATA_W-bit two's complement; Q entries are non-negative, so no overflow can occur.
REQ-016 SHALL compute sine and cosine in the same cycle from the same p, with cosine leading sine by exactly 64 samples.

Reset
REQ-017 SHALL, while rst=1, force p=0, sampled_sine=0x0000 and sampled_cosine=0x0000 immediately, independent of clk.
REQ-018 SHALL, on the first enabled edge after rst deasserts, output sampled_sine=0x0000 (S(0)) and sampled_cosine=0x7FFF (S(64)).
REQ-019 SHALL, when rst asserts mid-sequence, abandon the sequence; after release the sequence restarts at p=0.

Structure
REQ-020 SHALL place DATA_W, PHASE_W, AMPLITUDE=32767 and QUARTER_DEPTH=64 in a shared package (sin_cos_pkg).
REQ-021 SHALL implement the 65-entry quarter-wave table as one combinational sub-module, quarter_wave_rom, instantiated twice (sine and cosine) or time-shared; the top level holds the counter, quadrant folding and output registers.

Verification
REQ-022 Reset: rst=1 for 100 ns, en=0 -> both outputs 0x0000; release rst with en=1 -> first sample sine=0x0000, cosine=0x7FFF.
REQ-023 Key points: enabled edge n=17 (p=16) -> sine=12539; n=33 (p=32) -> sine=23170 and cosine=23170; n=65 (p=64) -> sine=0x7FFF, cosine=0x0000; n=129 (p=128) -> sine=0x0000, cosine=0x8001 (-32767); n=193 (p=192) -> sine=0x8001, cosine=0x0000.
REQ-024 Wrap: run 2000 enabled cycles and compare against a golden S(k) list -> sample n equals sample n+256 for all n, and sin^2+cos^2 is within 32767^2 +/- 2*32767.
REQ-025 Hold: deassert en for 10 cycles at p=100 -> outputs frozen; re-enable -> the next sample is S(100), with no skip.
REQ-026 Async reset mid-run: assert rst between clock edges at p=150 -> outputs go to 0 before the next edge; after release the sequence restarts from S(0).

Source files
------------

// File: rtl/sin_cos_pkg.sv
// Shared constants, quadrant types and the phase-folding helper for the
// sine/cosine generator.
package sin_cos_pkg;

  localparam int DATA_W        = 16;
  localparam int PHASE_W       = 8;
  localparam int AMPLITUDE     = 32767;
  localparam int QUARTER_DEPTH = 64;
  localparam int IDX_W         = $clog2(QUARTER_DEPTH + 1);
  localparam int ROM_W         = 16;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quadrant_e;

  typedef struct packed {
    logic             negate;
    logic [IDX_W-1:0] addr;
  } fold_t;

  // Quadrants 1 and 3 read the quarter table backwards, which is why it
  // has 65 entries: idx=0 there maps to Q[64], the peak.
  function automatic fold_t fold_phase(input logic [PHASE_W-1:0] k);
    fold_t            f;
    quadrant_e        quad;
    logic [IDX_W-1:0] idx;
    quad     = quadrant_e'(k[PHASE_W-1 -: 2]);
    idx      = IDX_W'(k[PHASE_W-3:0]);
    f.negate = (quad == QUAD_2) || (quad == QUAD_3);
    if ((quad == QUAD_1) || (quad == QUAD_3)) begin
      f.addr = IDX_W'(QUARTER_DEPTH) - idx;
    end else begin
      f.addr = idx;
    end
    return f;
  endfunction

endpackage

// File: rtl/quarter_wave_rom.sv
// 65-entry quarter-wave table: Q[i] = round(32767 * sin(2*pi*i/256)).
// Purely combinational; all entries are non-negative.
module quarter_wave_rom #(
  parameter int DATA_W = sin_cos_pkg::DATA_W
) (
  input  logic [sin_cos_pkg::IDX_W-1:0] addr,
  output logic [DATA_W-1:0]             data
);
  import sin_cos_pkg::*;

  logic [ROM_W-1:0] mag;

  // table lookup; addresses above 64 are never generated by the folding
  always_comb begin
    mag = '0;
    case (addr)
      7'd0:  mag = 16'd0;
      7'd1:  mag = 16'd804;
      7'd2:  mag = 16'd1608;
      7'd3:  mag = 16'd2410;
      7'd4:  mag = 16'd3212;
      7'd5:  mag = 16'd4011;
      7'd6:  mag = 16'd4808;
      7'd7:  mag = 16'd5602;
      7'd8:  mag = 16'd6393;
      7'd9:  mag = 16'd7179;
      7'd10: mag = 16'd7962;
      7'd11: mag = 16'd8739;
      7'd12: mag = 16'd9512;
      7'd13: mag = 16'd10278;
      7'd14: mag = 16'd11039;
      7'd15: mag = 16'd11793;
      7'd16: mag = 16'd12539;
      7'd17: mag = 16'd13279;
      7'd18: mag = 16'd14010;
      7'd19: mag = 16'd14732;
      7'd20: mag = 16'd15446;
      7'd21: mag = 16'd16151;
      7'd22: mag = 16'd16846;
      7'd23: mag = 16'd17530;
      7'd24: mag = 16'd18204;
      7'd25: mag = 16'd18868;
      7'd26: mag = 16'd19519;
      7'd27: mag = 16'd20159;
      7'd28: mag = 16'd20787;
      7'd29: mag = 16'd21403;
      7'd30: mag = 16'd22005;
      7'd31: mag = 16'd22594;
      7'd32: mag = 16'd23170;
      7'd33: mag = 16'd23731;
      7'd34: mag = 16'd24279;
      7'd35: mag = 16'd24811;
      7'd36: mag = 16'd25329;
      7'd37: mag = 16'd25832;
      7'd38: mag = 16'd26319;
      7'd39: mag = 16'd26790;
      7'd40: mag = 16'd27245;
      7'd41: mag = 16'd27683;
      7'd42: mag = 16'd28105;
      7'd43: mag = 16'd28510;
      7'd44: mag = 16'd28898;
      7'd45: mag = 16'd29268;
      7'd46: mag = 16'd29621;
      7'd47: mag = 16'd29956;
      7'd48: mag = 16'd30273;
      7'd49: mag = 16'd30571;
      7'd50: mag = 16'd30852;
      7'd51: mag = 16'd31113;
      7'd52: mag = 16'd31356;
      7'd53: mag = 16'd31580;
      7'd54: mag = 16'd31785;
      7'd55: mag = 16'd31971;
      7'd56: mag = 16'd32137;
      7'd57: mag = 16'd32285;
      7'd58: mag = 16'd32412;
      7'd59: mag = 16'd32521;
      7'd60: mag = 16'd32609;
      7'd61: mag = 16'd32678;
      7'd62: mag = 16'd32728;
      7'd63: mag = 16'd32757;
      7'd64: mag = ROM_W'(AMPLITUDE);
      default: mag = '0;
    endcase
  end

  assign data = DATA_W'(mag);

endmodule

// File: rtl/sin_cos_lut.sv
// Free-running sine/cosine sample generator: a phase counter advanced by en,
// quadrant folding into a shared quarter-wave table, registered outputs.
// The quarter table fixes the period at 256 samples (PHASE_W = 8).
module sin_cos_lut #(
  parameter int DATA_W  = sin_cos_pkg::DATA_W,
  parameter int PHASE_W = sin_cos_pkg::PHASE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [DATA_W-1:0] sampled_sine,
  output logic [DATA_W-1:0] sampled_cosine
);
  import sin_cos_pkg::*;

  logic [PHASE_W-1:0] p_q, p_d;
  logic [PHASE_W-1:0] cos_phase;
  fold_t              sin_fold, cos_fold;
  logic [DATA_W-1:0]  sin_mag, cos_mag;
  logic [DATA_W-1:0]  sine_q, sine_d;
  logic [DATA_W-1:0]  cosine_q, cosine_d;

  // cosine leads sine by a quarter period; fold both phases into table reads
  always_comb begin
    cos_phase = p_q + PHASE_W'(QUARTER_DEPTH);
    sin_fold  = fold_phase(p_q);
    cos_fold  = fold_phase(cos_phase);
  end

  quarter_wave_rom #(.DATA_W(DATA_W)) u_rom_sin (
    .addr (sin_fold.addr),
    .data (sin_mag)
  );

  quarter_wave_rom #(.DATA_W(DATA_W)) u_rom_cos (
    .addr (cos_fold.addr),
    .data (cos_mag)
  );

  // next phase and samples; everything holds while en is low
  always_comb begin
    p_d      = p_q;
    sine_d   = sine_q;
    cosine_d = cosine_q;
    if (en) begin
      p_d      = p_q + PHASE_W'(1);
      sine_d   = sin_fold.negate ? -sin_mag : sin_mag;
      cosine_d = cos_fold.negate ? -cos_mag : cos_mag;
    end
  end

  // state registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q      <= '0;
      sine_q   <= '0;
      cosine_q <= '0;
    end else begin
      p_q      <= p_d;
      sine_q   <= sine_d;
      cosine_q <= cosine_d;
    end
  end

  assign sampled_sine   = sine_q;
  assign sampled_cosine = cosine_q;

endmodule

// File: tb/tb_sin_cos_lut.sv
// Bench for sin_cos_lut: reference samples come from real-valued sine,
// randomized enable gaps, plus hold and asynchronous-reset scenarios.
module tb_sin_cos_lut;

  localparam real PI = 3.141592653589793;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] sampled_sine;
  logic [15:0] sampled_cosine;

  int n_checks = 0;
  int n_errors = 0;

  int golden[256];
  int n_en;
  int exp_sin;
  int exp_cos;

  always #5 clk = ~clk;

  sin_cos_lut #(.DATA_W(16), .PHASE_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .sampled_sine   (sampled_sine),
    .sampled_cosine (sampled_cosine)
  );

  function automatic int s_ref(input int k);
    real v;
    v = 32767.0 * $sin(2.0 * PI * real'(k % 256) / 256.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // update the model for one edge and compare; called #1 after the edge
  task automatic observe(input logic was_en);
    int  k;
    longint pwr;
    longint lim;
    k = n_en % 256;
    if (was_en) begin
      exp_sin = golden[k];
      exp_cos = golden[(k + 64) % 256];
      n_en++;
    end
    check("sine", sx(sampled_sine), exp_sin);
    check("cosine", sx(sampled_cosine), exp_cos);
    if (was_en) begin
      case (k)
        0:   begin check("key0_sin", sx(sampled_sine), 0);      check("key0_cos", sx(sampled_cosine), 32767);  end
        16:  check("key16_sin", sx(sampled_sine), 12539);
        32:  begin check("key32_sin", sx(sampled_sine), 23170);  check("key32_cos", sx(sampled_cosine), 23170);  end
        64:  begin check("key64_sin", sx(sampled_sine), 32767);  check("key64_cos", sx(sampled_cosine), 0);      end
        128: begin check("key128_sin", sx(sampled_sine), 0);     check("key128_cos", sx(sampled_cosine), -32767); end
        192: begin check("key192_sin", sx(sampled_sine), -32767); check("key192_cos", sx(sampled_cosine), 0);     end
        default: ;
      endcase
      pwr = longint'(sx(sampled_sine)) * sx(sampled_sine) + longint'(sx(sampled_cosine)) * sx(sampled_cosine);
      lim = 64'd32767 * 64'd32767;
      check("power", int'((pwr >= lim - 2 * 32767) && (pwr <= lim + 2 * 32767)), 1);
    end
  endtask

  task automatic tick(input logic en_val);
    @(negedge clk);
    en = en_val;
    @(posedge clk);
    #1;
    observe(en_val);
  endtask

  initial begin
    int done;
    logic b;
    for (int k = 0; k < 256; k++) golden[k] = s_ref(k);

    rst = 1'b1;
    en  = 1'b0;
    n_en = 0;
    exp_sin = 0;
    exp_cos = 0;
    #50;
    check("rst_sin", sx(sampled_sine), 0);
    check("rst_cos", sx(sampled_cosine), 0);
    #45;
    check("rst_sin_late", sx(sampled_sine), 0);
    check("rst_cos_late", sx(sampled_cosine), 0);

    // release with en already high: first edge must give S(0)/S(64)
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    @(posedge clk);
    #1;
    observe(1'b1);
    check("first_sin", sx(sampled_sine), 0);
    check("first_cos", sx(sampled_cosine), 32767);

    // long run with random enable gaps, crosses several wraps
    done = 1;
    while (done < 2000) begin
      b = ($urandom_range(0, 4) != 0);
      tick(b);
      if (b) done++;
    end

    // hold at p=100
    while ((n_en % 256) != 100) tick(1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      check("hold_sin", sx(sampled_sine), golden[99]);
      check("hold_cos", sx(sampled_cosine), golden[163]);
    end
    tick(1'b1);
    check("resume_sin", sx(sampled_sine), 20787);

    // asynchronous reset between edges at p=150
    while ((n_en % 256) != 150) tick(1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_sin", sx(sampled_sine), 0);
    check("async_rst_cos", sx(sampled_cosine), 0);
    n_en = 0;
    exp_sin = 0;
    exp_cos = 0;
    @(posedge clk);
    #1;
    check("rst_hold_sin", sx(sampled_sine), 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    @(posedge clk);
    #1;
    observe(1'b1);
    check("restart_sin", sx(sampled_sine), 0);
    check("restart_cos", sx(sampled_cosine), 32767);
    for (int i = 0; i < 40; i++) tick(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
